// File: rtl/ula_pkg.sv
// Shared raster timing constants and video RAM address formation for the ULA video reader.
package ula_pkg;

  localparam int unsigned H_TOTAL = 456;
  localparam int unsigned V_TOTAL = 311;

  localparam logic [8:0] H_LAST         = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST         = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_PAPER_FIRST  = 9'd8;
  localparam logic [8:0] H_PAPER_LAST   = 9'd263;
  localparam logic [8:0] H_FETCH_LAST   = 9'd255;
  localparam logic [8:0] V_PAPER_LAST   = 9'd191;
  localparam logic [8:0] H_BLANK_FIRST  = 9'd320;
  localparam logic [8:0] H_BLANK_LAST   = 9'd415;
  localparam logic [8:0] V_BLANK_FIRST  = 9'd240;
  localparam logic [8:0] V_BLANK_LAST   = 9'd255;
  localparam logic [8:0] H_SYNC_FIRST   = 9'd344;
  localparam logic [8:0] H_SYNC_LAST    = 9'd375;
  localparam logic [8:0] V_SYNC_FIRST   = 9'd248;
  localparam logic [8:0] V_SYNC_LAST    = 9'd251;
  localparam logic [8:0] IRQ_LINE       = 9'd248;
  localparam logic [8:0] IRQ_H_LAST     = 9'd71;
  localparam logic [8:0] H_CONTEND_LAST = 9'd263;

  typedef enum logic [1:0] {
    FETCH_NONE,
    FETCH_BITMAP,
    FETCH_ATTR
  } fetch_e;

  function automatic logic [12:0] vram_addr(input fetch_e kind, input logic [7:0] y,
                                            input logic [4:0] n);
    case (kind)
      FETCH_BITMAP: return {y[7:6], y[2:0], y[5:3], n};
      FETCH_ATTR:   return {3'b110, y[7:3], n};
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/ula_video_if.sv
// Video RAM read port (port 2 of the dual-port RAM) as seen by the ULA video reader.
interface ula_video_if;
  logic        vce;
  logic [12:0] va;
  logic [7:0]  vq;

  modport master (output vce, va, input vq);
  modport slave  (input vce, va, output vq);
endinterface

// File: rtl/ula_counters.sv
// Horizontal/vertical raster counters and 5-bit frame counter; exports the flash phase.
module ula_counters
  import ula_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       flash,
  output logic       line_end
);

  logic [4:0] frame;

  assign line_end = (hcount == H_LAST);
  assign flash    = frame[4];

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      frame  <= '0;
    end else if (ce) begin
      if (line_end) begin
        hcount <= '0;
        if (vcount == V_LAST) begin
          vcount <= '0;
          frame  <= frame + 5'd1;
        end else begin
          vcount <= vcount + 9'd1;
        end
      end else begin
        hcount <= hcount + 9'd1;
      end
    end
  end

endmodule

// File: rtl/ula_video.sv
// ZX Spectrum 128 ULA video reader: bitmap/attribute fetch, pixel shifter, colour, sync, blank, irq.
// Optional CPU contention output enabled by defining ULA_CONTENTION_EN.
module ula_video
  import ula_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [2:0]  border,
  ula_video_if.master vram,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        irq,
  input  logic        ca,
  output logic        contend
);

  logic [8:0] hcount, vcount;
  logic       flash, line_end;

  ula_counters u_counters (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .hcount   (hcount),
    .vcount   (vcount),
    .flash    (flash),
    .line_end (line_end)
  );

  logic       paper_line, fetch_h, paper, load;
  fetch_e     fetch;
  logic [7:0] bitmap_latch, attr_latch, shift_reg, attr_reg;
  logic [7:0] pix_bits, attr_cur;
  logic [2:0] colour;
  logic       bright, blank_next;

  assign paper_line = (vcount <= V_PAPER_LAST);
  assign fetch_h    = paper_line && (hcount <= H_FETCH_LAST);
  assign paper      = paper_line && (hcount >= H_PAPER_FIRST) && (hcount <= H_PAPER_LAST);
  assign load       = paper && (hcount[2:0] == 3'd0);

  // Fetch strobes are decoded straight from the counters so the RAM sees them in the same ce slot.
  always_comb begin
    fetch = FETCH_NONE;
    if (!reset && fetch_h) begin
      case (hcount[2:0])
        3'd0:    fetch = FETCH_BITMAP;
        3'd2:    fetch = FETCH_ATTR;
        default: fetch = FETCH_NONE;
      endcase
    end
  end

  assign vram.vce = (fetch != FETCH_NONE);
  assign vram.va  = vram_addr(fetch, vcount[7:0], hcount[7:3]);

  // On a load slot the first pixel comes straight from the latches, keeping one cycle of latency.
  assign pix_bits = load ? bitmap_latch : shift_reg;
  assign attr_cur = load ? attr_latch : attr_reg;

  always_comb begin
    colour     = border;
    bright     = 1'b0;
    blank_next = ((hcount >= H_BLANK_FIRST) && (hcount <= H_BLANK_LAST)) ||
                 ((vcount >= V_BLANK_FIRST) && (vcount <= V_BLANK_LAST));
    if (paper) begin
      colour = (pix_bits[7] ^ (attr_cur[7] & flash)) ? attr_cur[2:0] : attr_cur[5:3];
      bright = attr_cur[6];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitmap_latch <= '0;
      attr_latch   <= '0;
      shift_reg    <= '0;
      attr_reg     <= '0;
    end else if (ce) begin
      if (line_end) begin
        bitmap_latch <= '0;
        attr_latch   <= '0;
        shift_reg    <= '0;
        attr_reg     <= '0;
      end else begin
        shift_reg <= {pix_bits[6:0], 1'b0};
        attr_reg  <= attr_cur;
        if (fetch_h && hcount[2:0] == 3'd1) bitmap_latch <= vram.vq;
        if (fetch_h && hcount[2:0] == 3'd3) attr_latch   <= vram.vq;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {g, r, b} <= '0;
      i         <= 1'b0;
      blank     <= 1'b1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      irq       <= 1'b1;
    end else if (ce) begin
      {g, r, b} <= blank_next ? 3'b000 : colour;
      i         <= !blank_next && bright;
      blank     <= blank_next;
      hsync     <= !((hcount >= H_SYNC_FIRST) && (hcount <= H_SYNC_LAST));
      vsync     <= !((vcount >= V_SYNC_FIRST) && (vcount <= V_SYNC_LAST));
      irq       <= !((vcount == IRQ_LINE) && (hcount <= IRQ_H_LAST));
    end
  end

`ifdef ULA_CONTENTION_EN
  assign contend = !reset && ca && paper_line && (hcount <= H_CONTEND_LAST) &&
                   (hcount[3:0] < 4'd12);
`else
  // Contention disabled: ca is read but has no effect.
  assign contend = ca & 1'b0;
`endif

endmodule

// File: tb/tb_ula_video.sv
// Scoreboard bench for ula_video: random ce/border/ca, behavioural raster model, queued expectations.
module tb_ula_video;

  logic       clock = 1'b0;
  logic       reset, ce, ca;
  logic [2:0] border;
  logic       r, g, b, i, blank, hsync, vsync, irq, contend;

  ula_video_if vram ();

  ula_video dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .border  (border),
    .vram    (vram),
    .r       (r),
    .g       (g),
    .b       (b),
    .i       (i),
    .blank   (blank),
    .hsync   (hsync),
    .vsync   (vsync),
    .irq     (irq),
    .ca      (ca),
    .contend (contend)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:8191];

  always @(posedge clock) begin
    if (ce && vram.vce) vram.vq <= mem[vram.va];
  end

  typedef struct {
    logic [3:0]  rgbi;
    logic        blank;
    logic [2:0]  sync;
    logic        vce;
    logic [12:0] va;
    logic        contend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;

  int         m_h, m_v, m_fr;
  logic [3:0] m_rgbi;
  logic       m_blank;
  logic [2:0] m_sync;

  function automatic int bitmap_addr(input int y, input int n);
    return (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + n;
  endfunction

  function automatic int attr_addr(input int y, input int n);
    return 6144 + (y / 8) * 32 + n;
  endfunction

  // Returns {blank, r, g, b, i} for the pixel at raster position (h, v).
  function automatic logic [4:0] model_pixel(input int h, input int v, input int fr,
                                             input logic [2:0] bd);
    logic [7:0] bm, at;
    logic [2:0] c;
    logic       pbit;
    int         x;
    if ((h >= 320 && h <= 415) || (v >= 240 && v <= 255)) return 5'b10000;
    if (h >= 8 && h <= 263 && v < 192) begin
      x    = h - 8;
      bm   = mem[bitmap_addr(v, x / 8)];
      at   = mem[attr_addr(v, x / 8)];
      pbit = bm[7 - (x % 8)] ^ (at[7] && ((fr / 16) % 2 == 1));
      c    = pbit ? at[2:0] : at[5:3];
      return {1'b0, c[1], c[2], c[0], at[6]};
    end
    return {1'b0, bd[1], bd[2], bd[0], 1'b0};
  endfunction

  task automatic step(input logic rst_in);
    exp_t       e;
    logic [4:0] px;
    @(negedge clock);
    reset = rst_in;
    ce    = ($urandom_range(0, 9) != 0);
    ca    = ($urandom_range(0, 1) == 1);
    if ($urandom_range(0, 39) == 0) border = 3'($urandom_range(0, 7));
    if (rst_in) begin
      m_h = 0; m_v = 0; m_fr = 0;
      m_rgbi = 4'b0000; m_blank = 1'b1; m_sync = 3'b111;
    end else if (ce) begin
      px      = model_pixel(m_h, m_v, m_fr, border);
      m_blank = px[4];
      m_rgbi  = px[3:0];
      m_sync  = {!(m_h >= 344 && m_h <= 375), !(m_v >= 248 && m_v <= 251),
                 !(m_v == 248 && m_h < 72)};
      m_h++;
      if (m_h == 456) begin
        m_h = 0;
        m_v++;
        if (m_v == 311) begin
          m_v  = 0;
          m_fr = (m_fr + 1) % 32;
        end
      end
    end
    e.rgbi  = m_rgbi;
    e.blank = m_blank;
    e.sync  = m_sync;
    e.vce   = !rst_in && m_v < 192 && m_h < 256 && (m_h % 8 == 0 || m_h % 8 == 2);
    e.va    = '0;
    if (e.vce) e.va = 13'((m_h % 8 == 0) ? bitmap_addr(m_v, m_h / 8) : attr_addr(m_v, m_h / 8));
`ifdef ULA_CONTENTION_EN
    e.contend = !rst_in && ca && m_v < 192 && m_h <= 263 && (m_h % 16) < 12;
`else
    e.contend = 1'b0;
`endif
    q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (armed) begin
        if (q.size() == 0) begin
          check("queue_underrun", 13'd0, 13'd1);
        end else begin
          e = q.pop_front();
          check("rgbi", 13'({r, g, b, i}), 13'(e.rgbi));
          check("blank", 13'(blank), 13'(e.blank));
          check("sync_irq", 13'({hsync, vsync, irq}), 13'(e.sync));
          check("vce", 13'(vram.vce), 13'(e.vce));
          if (e.vce) check("va", vram.va, e.va);
          check("contend", 13'(contend), 13'(e.contend));
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    mem[13'h0000] = 8'h81;
    mem[13'h1800] = 8'h47;
    mem[13'h0123] = 8'h3C;
    mem[13'h1823] = 8'hB8;
    reset  = 1'b1;
    ce     = 1'b0;
    ca     = 1'b0;
    border = 3'b010;
    repeat (3) step(1'b1);
    repeat (8000) step(1'b0);
    repeat (2) step(1'b1);
    repeat (14000) step(1'b0);
    @(posedge clock);
    #2;
    check("queue_drained", 13'(q.size()), 13'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
